// File: rtl/binary_count_checker.sv
// binary_count_checker
// Samples a free-running binary counter and checks each sample is the
// previous sample plus one (mod 2^WIDTH). It locks after LOCK_N consecutive
// good increments. While locked, each break pulses error and bumps a
// saturating error counter. Every correct all-ones -> zero step pulses wrap.
module binary_count_checker #(
  parameter int WIDTH  = 4,
  parameter int LOCK_N = 4,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] binary,
  input  logic             err_clr,
  output logic             locked,
  output logic             error,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  localparam logic [7:0] LOCK_N_C = 8'(LOCK_N);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             have_prev_q, have_prev_d;
  logic [7:0]       run_q, run_d;
  logic             error_q, error_d;
  logic             wrap_q, wrap_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating increment: the error counter sticks at all-ones.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  // Next-state logic: capture, sequence check, lock FSM and error counting.
  always_comb begin
    logic [ERR_W-1:0] err_base;
    logic [7:0]       run_inc;
    logic             good;

    state_d     = state_q;
    prev_d      = prev_q;
    exp_d       = exp_q;
    have_prev_d = have_prev_q;
    run_d       = run_q;
    error_d     = 1'b0;
    wrap_d      = 1'b0;
    // Clear takes effect before any increment in the same cycle.
    err_base    = err_clr ? '0 : err_cnt_q;
    err_cnt_d   = err_base;
    run_inc     = run_q + 8'd1;
    good        = (binary == prev_q + WIDTH'(1));

    if (sample_en) begin
      prev_d      = binary;
      exp_d       = binary + WIDTH'(1);
      have_prev_d = 1'b1;
      // The first sample after reset only seeds prev; nothing is checked.
      if (have_prev_q) begin
        if (good) begin
          wrap_d = &prev_q;
          if (state_q == UNLOCKED) begin
            run_d = run_inc;
            if (run_inc >= LOCK_N_C) begin
              state_d = LOCKED;
            end
          end
        end else begin
          // Any break, including a repeated value, restarts acquisition.
          run_d = 8'd0;
          if (state_q == LOCKED) begin
            error_d   = 1'b1;
            err_cnt_d = sat_inc(err_base);
            state_d   = UNLOCKED;
          end
        end
      end
    end
  end

  // State and output registers, all cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= UNLOCKED;
      prev_q      <= '0;
      exp_q       <= '0;
      have_prev_q <= 1'b0;
      run_q       <= 8'd0;
      error_q     <= 1'b0;
      wrap_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      exp_q       <= exp_d;
      have_prev_q <= have_prev_d;
      run_q       <= run_d;
      error_q     <= error_d;
      wrap_q      <= wrap_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign error     = error_q;
  assign wrap      = wrap_q;
  assign err_count = err_cnt_q;
  assign expected  = exp_q;

endmodule

// File: tb/tb_binary_count_checker.sv
// Testbench for binary_count_checker: directed scenarios plus randomized
// traffic, scored against a sample-history reference model. Two instances
// share stimulus; the second has a 2-bit error counter to reach saturation.
module tb_binary_count_checker;

  localparam int WIDTH  = 4;
  localparam int LOCK_N = 4;
  localparam int MOD    = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_en;
  logic       err_clr;
  logic [3:0] binary;

  logic       locked, error, wrap;
  logic [7:0] err_count;
  logic [3:0] expected;
  logic       locked2, error2, wrap2;
  logic [1:0] err_count2;
  logic [3:0] expected2;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (plain integers).
  int m_have, m_prev, m_run, m_locked, m_error, m_wrap, m_cnt8, m_cnt2, m_exp;

  always #5 clk = ~clk;

  binary_count_checker #(.WIDTH(WIDTH), .LOCK_N(LOCK_N), .ERR_W(8)) u_dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .binary(binary),
    .err_clr(err_clr), .locked(locked), .error(error), .wrap(wrap),
    .err_count(err_count), .expected(expected)
  );

  binary_count_checker #(.WIDTH(WIDTH), .LOCK_N(LOCK_N), .ERR_W(2)) u_dut_e2 (
    .clk(clk), .reset(reset), .sample_en(sample_en), .binary(binary),
    .err_clr(err_clr), .locked(locked2), .error(error2), .wrap(wrap2),
    .err_count(err_count2), .expected(expected2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_have = 0; m_prev = 0; m_run = 0; m_locked = 0;
    m_error = 0; m_wrap = 0; m_cnt8 = 0; m_cnt2 = 0; m_exp = 0;
  endtask

  // Apply the checker's rules to one clock edge of stimulus.
  task automatic model_sample(input bit en, input int val, input bit clr);
    m_error = 0;
    m_wrap  = 0;
    if (clr) begin
      m_cnt8 = 0;
      m_cnt2 = 0;
    end
    if (en) begin
      if (m_have) begin
        if (val == (m_prev + 1) % MOD) begin
          if (m_prev == MOD - 1) m_wrap = 1;
          if (!m_locked) begin
            m_run++;
            if (m_run >= LOCK_N) m_locked = 1;
          end
        end else begin
          m_run = 0;
          if (m_locked) begin
            m_error  = 1;
            m_locked = 0;
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3)   m_cnt2++;
          end
        end
      end
      m_have = 1;
      m_prev = val;
      m_exp  = (val + 1) % MOD;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".locked"},    locked,     m_locked);
    check({tag, ".error"},     error,      m_error);
    check({tag, ".wrap"},      wrap,       m_wrap);
    check({tag, ".err_count"}, err_count,  m_cnt8);
    check({tag, ".expected"},  expected,   m_exp);
    check({tag, ".locked2"},   locked2,    m_locked);
    check({tag, ".error2"},    error2,     m_error);
    check({tag, ".wrap2"},     wrap2,      m_wrap);
    check({tag, ".err_cnt2"},  err_count2, m_cnt2);
    check({tag, ".expected2"}, expected2,  m_exp);
  endtask

  // Drive one cycle of stimulus, let the edge sample it, then score.
  task automatic step(input bit en, input int val, input bit clr);
    sample_en = en;
    binary    = val[3:0];
    err_clr   = clr;
    @(posedge clk);
    model_sample(en, val, clr);
    #1;
    check_all($sformatf("step(en=%0d,v=%0d,clr=%0d)", en, val, clr));
  endtask

  // Pulse reset between edges; outputs must clear without waiting for clk.
  task automatic pulse_reset();
    sample_en = 1'b0;
    err_clr   = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int v;
    reset     = 1'b0;
    sample_en = 1'b0;
    err_clr   = 1'b0;
    binary    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b1;

    // Acquisition
    for (int i = 0; i <= 4; i++) begin
      step(1'b1, i, 1'b0);
      check($sformatf("acq_locked_%0d", i), locked, (i == 4) ? 1 : 0);
      check($sformatf("acq_error_%0d", i), error, 0);
    end
    check("acq_expected", expected, 5);

    // Wrap while locked
    for (int i = 5; i <= 12; i++) step(1'b1, i, 1'b0);
    for (int i = 13; i <= 17; i++) begin
      step(1'b1, i % MOD, 1'b0);
      check($sformatf("wrap_pulse_%0d", i % MOD), wrap, (i == 16) ? 1 : 0);
      check($sformatf("wrap_locked_%0d", i % MOD), locked, 1);
    end
    check("wrap_err_count", err_count, 0);

    // Sequence break at 5 -> 9, then relock
    for (int i = 2; i <= 5; i++) step(1'b1, i, 1'b0);
    step(1'b1, 9, 1'b0);
    check("break_error", error, 1);
    check("break_count", err_count, 1);
    check("break_locked", locked, 0);
    check("break_expected", expected, 10);
    for (int i = 10; i <= 13; i++) begin
      step(1'b1, i, 1'b0);
      check($sformatf("relock_error_%0d", i), error, 0);
      check($sformatf("relock_locked_%0d", i), locked, (i == 13) ? 1 : 0);
    end

    // Stall and gating
    for (int i = 14; i <= 23; i++) step(1'b1, i % MOD, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, $urandom_range(0, 15), 1'b0);
      check("gate_locked", locked, 1);
      check("gate_expected", expected, 8);
    end
    step(1'b1, 8, 1'b0);
    check("reenable_error", error, 0);
    step(1'b1, 8, 1'b0);
    check("repeat_error", error, 1);
    check("repeat_count", err_count, 2);

    // Reset mid-operation
    for (int i = 9; i <= 12; i++) step(1'b1, i, 1'b0);
    check("pre_reset_locked", locked, 1);
    check("pre_reset_count", err_count, 2);
    pulse_reset();
    check("mid_reset_locked", locked, 0);
    check("mid_reset_count", err_count, 0);
    step(1'b1, 6, 1'b0);
    check("post_reset_error", error, 0);
    check("post_reset_expected", expected, 7);

    // Saturation with a 2-bit counter, then clear interactions
    v = 6;
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 4; j++) begin
        v = (v + 1) % MOD;
        step(1'b1, v, 1'b0);
      end
      v = (v + 5) % MOD;
      step(1'b1, v, 1'b0);
      check($sformatf("sat_break_error_%0d", k), error2, 1);
    end
    check("sat_count2", err_count2, 3);
    check("sat_count8", err_count, 5);
    for (int j = 0; j < 4; j++) begin
      v = (v + 1) % MOD;
      step(1'b1, v, 1'b0);
    end
    v = (v + 3) % MOD;
    step(1'b1, v, 1'b1);
    check("clr_with_err_count2", err_count2, 1);
    check("clr_with_err_count8", err_count, 1);
    step(1'b0, 0, 1'b1);
    check("clr_alone_count2", err_count2, 0);
    check("clr_alone_count8", err_count, 0);

    // Randomized traffic: mostly correct increments, with gaps, breaks,
    // repeats, clears and occasional resets.
    for (int n = 0; n < 600; n++) begin
      int r;
      bit en;
      bit clr;
      r   = $urandom_range(0, 99);
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      if (r < 80)      v = (m_prev + 1) % MOD;
      else if (r < 88) v = m_prev;
      else             v = $urandom_range(0, 15);
      if ($urandom_range(0, 149) == 0) pulse_reset();
      step(en, v, clr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
